mips_forward_unit: RTL and testbench
====================================

MIPS_FORWARD_UNIT -- requirements
Module: mips_forward_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port freeze  input  1  global pipeline hold; no slot advances.
REQ-006 SHALL have port id_valid  input  1  ID-stage instruction is real (not a bubble).
REQ-007 SHALL have port id_rs / id_rt  input  REG_AW each  ID-stage source registers.
REQ-008 SHALL have port id_use_rs / id_use_rt  input  1 each  instruction reads rs / rt.
REQ-009 SHALL have port id_dst  input  REG_AW  ID-stage destination register.
REQ-010 SHALL have port id_reg_write / id_mem_read  input  1 each  writes register / is a load.
REQ-011 SHALL have port fwd_a / fwd_b  output  2 each  EX-stage operand-mux select for rs / rt.
REQ-012 SHALL have port stall  output  1  load-use hazard; hold PC and IF/ID.
REQ-013 SHALL have port stall_count  output  CNT_W  saturating count of load-use stall cycles.

Function
REQ-014 SHALL hold three destination slots EX, MEM, WB, each {valid, dst, reg_write, mem_read}.
REQ-015 SHALL encode select: 2'b00 register file, 2'b01 EX/MEM result, 2'b10 MEM/WB result; 2'b11 never driven.
REQ-016 SHALL, per edge with freeze=0 and stall=0: EX<=ID info (valid=id_valid), MEM<=EX, WB<=MEM.
REQ-017 SHALL register fwd_a/fwd_b on the same edge the ID instruction enters EX (latency 1 cycle, valid while it sits in EX).
REQ-018 SHALL set fwd_a=01 when id_use_rs, id_rs!=0 and current EX slot is valid, reg_write, non-load, dst==id_rs.
REQ-019 SHALL otherwise set fwd_a=10 when id_use_rs, id_rs!=0 and current MEM slot is valid, reg_write, dst==id_rs.
REQ-020 SHALL otherwise set fwd_a=00; fwd_b identically from id_rt/id_use_rt.
REQ-021 SHALL give EX-slot match priority over MEM-slot match (youngest producer wins).
REQ-022 SHALL drive stall combinationally =1 when id_valid, EX slot valid and mem_read, EX.dst!=0, and (id_use_rs & id_rs==EX.dst or id_use_rt & id_rt==EX.dst).
REQ-023 SHALL, on edge with stall=1 and freeze=0: EX<=bubble (valid=0), MEM<=EX, WB<=MEM, fwd_a/fwd_b<=00.
REQ-024 SHALL, after one stall cycle, resolve the held instruction via MEM/WB path (fwd=10), never a second stall for the same load.
REQ-025 SHALL, with freeze=1: hold all slots, fwd outputs and stall_count; stall output still reflects current hazard.
REQ-026 SHALL increment stall_count on each edge with stall=1 and freeze=0; saturate at all-ones.
REQ-027 SHALL never forward register 0, regardless of slot contents.
REQ-028 SHALL ignore id_* inputs when id_valid=0 (EX gets bubble, fwd=00, no stall).

Reset
REQ-029 SHALL, on reset assertion at any time, immediately clear all slot valid bits, fwd_a=fwd_b=00, stall_count=0.
REQ-030 SHALL drive stall=0 while reset asserted; first update on first edge after deassertion.

Structure
REQ-031 SHALL place FWD_REG/FWD_EXMEM/FWD_MEMWB constants and the slot typedef in shared package mips_pkg.
REQ-032 SHALL use one sub-module mips_fwd_select (per-operand match and priority), instantiated twice.
REQ-033 SHALL keep select encoding identical to the existing 3:1 operand mux so outputs drive it directly.

Verification
REQ-034 SHALL test: add $3 then add uses $3 as rs -> fwd_a=01 next cycle, fwd_b=00.
REQ-035 SHALL test: add $3, nop, sub uses $3 as rt -> fwd_b=10; add $3 then add $3 both older -> youngest (01) wins.
REQ-036 SHALL test: lw $5 then add reads $5 -> stall=1 one cycle, stall_count=1, then fwd=10, stall=0.
REQ-037 SHALL test: producer writes $0, consumer reads $0 -> fwd=00, no stall.
REQ-038 SHALL test: freeze=1 during load-use hazard for 3 cycles -> slots, fwd, stall_count unchanged; stall stays 1.
REQ-039 SHALL test: reset asserted mid-hazard, between edges -> fwd=00, stall=0, stall_count=0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS forwarding/hazard logic: operand-mux select codes
// and the per-stage destination-slot record.
package mips_pkg;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   // Slots hold register numbers at a fixed width; narrower REG_AW values are zero-extended.
   localparam int SLOT_AW = 8;

   typedef struct packed {
      logic               valid;
      logic [SLOT_AW-1:0] dst;
      logic               reg_write;
      logic               mem_read;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '{valid: 1'b0, dst: {SLOT_AW{1'b0}}, reg_write: 1'b0, mem_read: 1'b0};

   // True when the slot holds a real instruction that will write register r (never $0).
   function automatic logic slot_produces(input slot_t s, input logic [SLOT_AW-1:0] r);
      return s.valid && s.reg_write && (s.dst == r) && (r != {SLOT_AW{1'b0}});
   endfunction

endpackage

// File: rtl/mips_fwd_select.sv
// Per-operand forwarding select: matches one source register against the EX and MEM
// slots and picks the youngest usable producer.
module mips_fwd_select
   import mips_pkg::*;
(
   input  logic               use_src,
   input  logic [SLOT_AW-1:0] src,
   input  slot_t              ex_slot,
   input  slot_t              mem_slot,
   output logic [1:0]         sel
);

   // A load still in EX has no data yet; that case is covered by the stall, not here.
   always_comb begin
      sel = FWD_REG;
      if (use_src && slot_produces(ex_slot, src) && !ex_slot.mem_read) begin
         sel = FWD_EXMEM;
      end else if (use_src && slot_produces(mem_slot, src)) begin
         sel = FWD_MEMWB;
      end else begin
         sel = FWD_REG;
      end
   end

endmodule

// File: rtl/mips_forward_unit.sv
// EX-stage operand forwarding and load-use stall detection for a 5-stage MIPS pipeline,
// tracking the destinations of the instructions in EX, MEM and WB.
module mips_forward_unit
   import mips_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              freeze,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] id_dst,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_count
);

   slot_t              ex_slot;
   slot_t              mem_slot;
   slot_t              wb_slot;
   slot_t              id_slot;
   logic [SLOT_AW-1:0] rs_ext;
   logic [SLOT_AW-1:0] rt_ext;
   logic [1:0]         sel_a;
   logic [1:0]         sel_b;
   logic               hazard;

   assign rs_ext = SLOT_AW'(id_rs);
   assign rt_ext = SLOT_AW'(id_rt);

   // Pack the ID-stage instruction into the record that enters EX.
   always_comb begin
      id_slot           = SLOT_EMPTY;
      id_slot.valid     = id_valid;
      id_slot.dst       = SLOT_AW'(id_dst);
      id_slot.reg_write = id_reg_write;
      id_slot.mem_read  = id_mem_read;
   end

   // Load in EX whose result the ID instruction needs: one bubble lets it reach MEM.
   always_comb begin
      hazard = 1'b0;
      if (id_valid && ex_slot.valid && ex_slot.mem_read && (ex_slot.dst != {SLOT_AW{1'b0}})) begin
         hazard = (id_use_rs && (rs_ext == ex_slot.dst)) || (id_use_rt && (rt_ext == ex_slot.dst));
      end else begin
         hazard = 1'b0;
      end
   end

   assign stall = hazard && !reset;

   mips_fwd_select u_sel_a (
      .use_src  (id_valid && id_use_rs),
      .src      (rs_ext),
      .ex_slot  (ex_slot),
      .mem_slot (mem_slot),
      .sel      (sel_a)
   );

   mips_fwd_select u_sel_b (
      .use_src  (id_valid && id_use_rt),
      .src      (rt_ext),
      .ex_slot  (ex_slot),
      .mem_slot (mem_slot),
      .sel      (sel_b)
   );

   // Slot shift, registered selects and stall counter; freeze holds everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_slot     <= SLOT_EMPTY;
         mem_slot    <= SLOT_EMPTY;
         wb_slot     <= SLOT_EMPTY;
         fwd_a       <= FWD_REG;
         fwd_b       <= FWD_REG;
         stall_count <= {CNT_W{1'b0}};
      end else if (freeze) begin
         ex_slot     <= ex_slot;
         mem_slot    <= mem_slot;
         wb_slot     <= wb_slot;
         fwd_a       <= fwd_a;
         fwd_b       <= fwd_b;
         stall_count <= stall_count;
      end else if (stall) begin
         ex_slot  <= SLOT_EMPTY;
         mem_slot <= ex_slot;
         wb_slot  <= mem_slot;
         fwd_a    <= FWD_REG;
         fwd_b    <= FWD_REG;
         if (stall_count != {CNT_W{1'b1}}) begin
            stall_count <= stall_count + CNT_W'(1'b1);
         end else begin
            stall_count <= stall_count;
         end
      end else begin
         ex_slot     <= id_slot;
         mem_slot    <= ex_slot;
         wb_slot     <= mem_slot;
         fwd_a       <= sel_a;
         fwd_b       <= sel_b;
         stall_count <= stall_count;
      end
   end

endmodule

// File: tb/tb_mips_forward_unit.sv
// Self-checking bench for mips_forward_unit: directed pipeline scenarios plus randomized
// instruction streams checked against a producer-distance model of the pipeline.
module tb_mips_forward_unit;

   localparam int REG_AW  = 5;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              freeze = 1'b0;
   logic              id_valid = 1'b0;
   logic [REG_AW-1:0] id_rs = '0;
   logic [REG_AW-1:0] id_rt = '0;
   logic              id_use_rs = 1'b0;
   logic              id_use_rt = 1'b0;
   logic [REG_AW-1:0] id_dst = '0;
   logic              id_reg_write = 1'b0;
   logic              id_mem_read = 1'b0;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
   logic              stall;
   logic [CNT_W-1:0]  stall_count;

   int n_vec = 0;
   int n_bad = 0;

   // Model: instructions that entered EX, newest first (0 = now in EX, 1 = now in MEM).
   typedef struct { bit v; int dst; bit rw; bit ld; } ins_t;
   ins_t hist[$];
   int   m_count = 0;
   int   m_fa = 0;
   int   m_fb = 0;
   bit   exp_stall;

   logic             obs_stall;
   logic [1:0]       obs_fa;
   logic [1:0]       obs_fb;
   logic [CNT_W-1:0] obs_cnt;

   mips_forward_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .freeze       (freeze),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .id_dst       (id_dst),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .stall        (stall),
      .stall_count  (stall_count)
   );

   always #5 clk = ~clk;

   function automatic int expect_sel(bit use_it, int r);
      if (!id_valid || !use_it || r == 0) return 0;
      if (hist.size() > 0 && hist[0].v && hist[0].rw && !hist[0].ld && hist[0].dst == r) return 1;
      if (hist.size() > 1 && hist[1].v && hist[1].rw && hist[1].dst == r) return 2;
      return 0;
   endfunction

   function automatic bit expect_stall_now();
      if (!id_valid || hist.size() == 0) return 1'b0;
      if (!hist[0].v || !hist[0].ld || hist[0].dst == 0) return 1'b0;
      return (id_use_rs && int'(id_rs) == hist[0].dst) || (id_use_rt && int'(id_rt) == hist[0].dst);
   endfunction

   task automatic apply(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input int dst, input bit rw, input bit ld, input bit frz);
      ins_t e;
      int   na;
      int   nb;
      bit   st;
      @(negedge clk);
      id_valid = v; id_rs = REG_AW'(rs); id_rt = REG_AW'(rt);
      id_use_rs = urs; id_use_rt = urt; id_dst = REG_AW'(dst);
      id_reg_write = rw; id_mem_read = ld; freeze = frz;
      #1;
      st = expect_stall_now();
      na = expect_sel(urs, rs);
      nb = expect_sel(urt, rt);
      exp_stall = st;
      obs_stall = stall;
      @(posedge clk);
      #1;
      if (!frz) begin
         if (st) begin
            e = '{v: 1'b0, dst: 0, rw: 1'b0, ld: 1'b0};
            m_fa = 0; m_fb = 0;
            if (m_count < CNT_MAX) m_count++;
         end else begin
            e = '{v: v, dst: dst, rw: rw, ld: ld};
            m_fa = na; m_fb = nb;
         end
         hist.push_front(e);
         if (hist.size() > 2) void'(hist.pop_back());
      end
      obs_fa = fwd_a; obs_fb = fwd_b; obs_cnt = stall_count;
   endtask

   task automatic alu(input int rs, input int rt, input int dst);
      apply(1'b1, rs, rt, 1'b1, 1'b1, dst, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic lw(input int rs, input int dst);
      apply(1'b1, rs, 0, 1'b1, 1'b0, dst, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic nop();
      apply(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; freeze = 1'b0; id_valid = 1'b0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      id_reg_write = 1'b0; id_mem_read = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      hist.delete(); m_count = 0; m_fa = 0; m_fb = 0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_vec++; if (fwd_a !== 2'b00) begin n_bad++; $display("FAIL reset_fwd_a: got %b want 00", fwd_a); end
      n_vec++; if (fwd_b !== 2'b00) begin n_bad++; $display("FAIL reset_fwd_b: got %b want 00", fwd_b); end
      n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
      n_vec++; if (stall_count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", stall_count); end
   endtask

   task automatic test_ex_forward();
      do_reset();
      alu(1, 2, 3);
      alu(3, 4, 6);
      n_vec++; if (obs_fa !== 2'b01) begin n_bad++; $display("FAIL ex_fwd_a: got %b want 01", obs_fa); end
      n_vec++; if (obs_fb !== 2'b00) begin n_bad++; $display("FAIL ex_fwd_b: got %b want 00", obs_fb); end
      n_vec++; if (obs_stall !== 1'b0) begin n_bad++; $display("FAIL ex_stall: got %b want 0", obs_stall); end
   endtask

   task automatic test_mem_forward();
      do_reset();
      alu(1, 2, 3);
      nop();
      alu(1, 3, 8);
      n_vec++; if (obs_fb !== 2'b10) begin n_bad++; $display("FAIL mem_fwd_b: got %b want 10", obs_fb); end
      n_vec++; if (obs_fa !== 2'b00) begin n_bad++; $display("FAIL mem_fwd_a: got %b want 00", obs_fa); end
   endtask

   task automatic test_youngest();
      do_reset();
      alu(1, 2, 3);
      alu(1, 2, 3);
      alu(3, 1, 9);
      n_vec++; if (obs_fa !== 2'b01) begin n_bad++; $display("FAIL youngest_fwd_a: got %b want 01", obs_fa); end
   endtask

   task automatic test_load_use();
      do_reset();
      lw(1, 5);
      alu(5, 2, 7);
      n_vec++; if (obs_stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b want 1", obs_stall); end
      n_vec++; if (obs_cnt !== 4'd1) begin n_bad++; $display("FAIL lu_count: got %0d want 1", obs_cnt); end
      n_vec++; if (obs_fa !== 2'b00) begin n_bad++; $display("FAIL lu_bubble_fwd: got %b want 00", obs_fa); end
      alu(5, 2, 7);
      n_vec++; if (obs_stall !== 1'b0) begin n_bad++; $display("FAIL lu_restall: got %b want 0", obs_stall); end
      n_vec++; if (obs_fa !== 2'b10) begin n_bad++; $display("FAIL lu_fwd_a: got %b want 10", obs_fa); end
      n_vec++; if (obs_cnt !== 4'd1) begin n_bad++; $display("FAIL lu_count_after: got %0d want 1", obs_cnt); end
   endtask

   task automatic test_zero_reg();
      do_reset();
      alu(1, 2, 0);
      alu(0, 0, 4);
      n_vec++; if ({obs_fa, obs_fb} !== 4'b0000) begin n_bad++; $display("FAIL zero_fwd: got %b want 0000", {obs_fa, obs_fb}); end
      lw(1, 0);
      alu(0, 0, 4);
      n_vec++; if (obs_stall !== 1'b0) begin n_bad++; $display("FAIL zero_stall: got %b want 0", obs_stall); end
   endtask

   task automatic test_freeze();
      do_reset();
      alu(1, 2, 7);
      lw(7, 5);
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 5, 2, 1'b1, 1'b1, 9, 1'b1, 1'b0, 1'b1);
         n_vec++; if (obs_stall !== 1'b1) begin n_bad++; $display("FAIL frz_stall[%0d]: got %b want 1", i, obs_stall); end
         n_vec++; if (obs_fa !== 2'b01) begin n_bad++; $display("FAIL frz_fwd_a[%0d]: got %b want 01", i, obs_fa); end
         n_vec++; if (obs_cnt !== 4'd0) begin n_bad++; $display("FAIL frz_count[%0d]: got %0d want 0", i, obs_cnt); end
      end
      alu(5, 2, 9);
      n_vec++; if (obs_stall !== 1'b1) begin n_bad++; $display("FAIL frz_release_stall: got %b want 1", obs_stall); end
      n_vec++; if (obs_cnt !== 4'd1) begin n_bad++; $display("FAIL frz_release_count: got %0d want 1", obs_cnt); end
      alu(5, 2, 9);
      n_vec++; if (obs_fa !== 2'b10) begin n_bad++; $display("FAIL frz_resolve_fwd: got %b want 10", obs_fa); end
   endtask

   task automatic test_reset_mid_hazard();
      do_reset();
      lw(1, 5);
      alu(5, 2, 7);
      alu(5, 2, 7);
      lw(7, 6);
      @(negedge clk);
      id_valid = 1'b1; id_rs = 5'd0; id_rt = 5'd6; id_use_rs = 1'b0; id_use_rt = 1'b1;
      id_dst = 5'd9; id_reg_write = 1'b1; id_mem_read = 1'b0; freeze = 1'b0;
      #1;
      n_vec++; if (stall !== 1'b1) begin n_bad++; $display("FAIL mid_pre_stall: got %b want 1", stall); end
      n_vec++; if (fwd_a !== 2'b01) begin n_bad++; $display("FAIL mid_pre_fwd_a: got %b want 01", fwd_a); end
      n_vec++; if (stall_count !== 4'd1) begin n_bad++; $display("FAIL mid_pre_count: got %0d want 1", stall_count); end
      #1;
      reset = 1'b1;
      #1;
      n_vec++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_fwd: got %b want 0000", {fwd_a, fwd_b}); end
      n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mid_rst_stall: got %b want 0", stall); end
      n_vec++; if (stall_count !== 4'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d want 0", stall_count); end
      @(negedge clk);
      reset = 1'b0; id_valid = 1'b0;
      hist.delete(); m_count = 0; m_fa = 0; m_fb = 0;
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         lw(1, 5);
         apply(1'b1, 5, 0, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b0);
         apply(1'b1, 5, 0, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b0);
      end
      n_vec++; if (obs_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_count: got %0d want 15", obs_cnt); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         apply($urandom_range(0, 99) < 85, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
               $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10);
         n_vec++; if (obs_stall !== exp_stall) begin n_bad++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, obs_stall, exp_stall); end
         n_vec++; if (obs_fa !== 2'(m_fa)) begin n_bad++; $display("FAIL rnd_fwd_a[%0d]: got %b want %0d", i, obs_fa, m_fa); end
         n_vec++; if (obs_fb !== 2'(m_fb)) begin n_bad++; $display("FAIL rnd_fwd_b[%0d]: got %b want %0d", i, obs_fb, m_fb); end
         n_vec++; if (int'(obs_cnt) != m_count) begin n_bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, obs_cnt, m_count); end
      end
   endtask

   initial begin
      test_reset();
      test_ex_forward();
      test_mem_forward();
      test_youngest();
      test_load_use();
      test_zero_reg();
      test_freeze();
      test_reset_mid_hazard();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
